// File: rtl/hept_stage_sequencer.sv
// Sequences the HEPT attention sub-kernels one at a time behind a single ap_ctrl_hs handshake,
// with per-stage cycle profiling and a per-stage watchdog.
module hept_stage_sequencer #(
  parameter int unsigned N_STAGES = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 4096,
  localparam int unsigned IW      = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      ap_start,
  input  logic                      ap_continue,
  output logic                      ap_idle,
  output logic                      ap_ready,
  output logic                      ap_done,
  input  logic [N_STAGES-1:0]       stage_skip,
  output logic [N_STAGES-1:0]       stage_start,
  input  logic [N_STAGES-1:0]       stage_ready,
  input  logic [N_STAGES-1:0]       stage_done,
  output logic [IW-1:0]             busy_stage,
  output logic [N_STAGES*CNT_W-1:0] stage_cycles,
  output logic                      err_timeout,
  output logic [IW-1:0]             err_stage
);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StDone, StAbort} state_e;

  state_e                             state_q, state_d;
  logic [IW-1:0]                      idx_q, idx_d;
  logic [N_STAGES-1:0]                skip_q, skip_d;
  logic [N_STAGES-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic                               ready_q, ready_d;
  logic                               err_to_q, err_to_d;
  logic [IW-1:0]                      err_stage_q, err_stage_d;

  logic                               first_found, next_found;
  logic [IW-1:0]                      first_idx, next_idx;
  logic                               cur_done, cur_ready, timeout_hit;
  logic [31:0]                        cnt_ext;

  // First runnable stage uses the live mask (acceptance cycle); later ones use the latched mask.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int k = 0; k < int'(N_STAGES); k++) begin
      if (!first_found && !stage_skip[k]) begin
        first_found = 1'b1;
        first_idx   = IW'(k);
      end
      if (!next_found && !skip_q[k] && (k > int'(idx_q))) begin
        next_found = 1'b1;
        next_idx   = IW'(k);
      end
    end
  end

  assign cur_done    = stage_done[idx_q];
  assign cur_ready   = stage_ready[idx_q];
  assign cnt_ext     = 32'(cnt_q[idx_q]);
  // Fires in the cycle whose count would make the counter equal TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && ((cnt_ext + 32'd1) >= TIMEOUT);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    skip_d      = skip_q;
    cnt_d       = cnt_q;
    ready_d     = 1'b0;
    err_to_d    = err_to_q;
    err_stage_d = err_stage_q;
    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          ready_d     = 1'b1;
          skip_d      = stage_skip;
          cnt_d       = '0;
          err_to_d    = 1'b0;
          err_stage_d = '0;
          if (first_found) begin
            state_d = StLaunch;
            idx_d   = first_idx;
          end else begin
            state_d = StDone;
            idx_d   = '0;
          end
        end
      end
      StLaunch, StWait: begin
        if (cnt_q[idx_q] != {CNT_W{1'b1}}) begin
          cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
        end
        if (cur_done) begin
          if (next_found) begin
            state_d = StLaunch;
            idx_d   = next_idx;
          end else begin
            state_d = StDone;
            idx_d   = '0;
          end
        end else if (timeout_hit) begin
          state_d     = StAbort;
          err_to_d    = 1'b1;
          err_stage_d = idx_q;
        end else if ((state_q == StLaunch) && cur_ready) begin
          state_d = StWait;
        end
      end
      StAbort: begin
        state_d = StDone;
        idx_d   = '0;
      end
      StDone: begin
        if (ap_continue) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      skip_q      <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      err_to_q    <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      skip_q      <= skip_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      err_to_q    <= err_to_d;
      err_stage_q <= err_stage_d;
    end
  end

  always_comb begin
    stage_start = '0;
    if (state_q == StLaunch) begin
      stage_start[idx_q] = 1'b1;
    end
  end

  assign ap_idle      = (state_q == StIdle);
  assign ap_done      = (state_q == StDone);
  assign ap_ready     = ready_q;
  assign busy_stage   = ((state_q == StLaunch) || (state_q == StWait)) ? idx_q : '0;
  assign stage_cycles = cnt_q;
  assign err_timeout  = err_to_q;
  assign err_stage    = err_stage_q;

endmodule

// File: doc/hept_stage_sequencer.md
# hept_stage_sequencer

Sequencer for the HEPT attention kernel. It runs the four `ap_ctrl_hs` sub-kernels one at a time, in this order:

- stage 0: transpose_qk (Q)
- stage 1: transpose_qk (K)
- stage 2: pairwise_dist_sq_rbf
- stage 3: mask_and_normalize

It presents a single `ap_ctrl_hs` interface upward to myproject. It also records per-stage cycle counts for profiling and applies a per-stage watchdog so a hung kernel cannot stall the top level.

## Interface
Parameters:
- N_STAGES, 4, number of sequenced sub-kernels; stage index order is execution order.
- CNT_W, 16, width of each per-stage cycle counter.
- TIMEOUT, 4096, per-stage cycle limit before abort; 0 disables the watchdog.

Ports (IW = $clog2(N_STAGES)):
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- ap_start  in  1  run request from the top level.
- ap_continue  in  1  top level acknowledges ap_done.
- ap_idle  out  1  high in IDLE only.
- ap_ready  out  1  one-cycle pulse; the run has been accepted.
- ap_done  out  1  held high until ap_continue is sampled high.
- stage_skip  in  N_STAGES  bypass mask; sampled only in the acceptance cycle.
- stage_start  out  N_STAGES  one-hot; at most one bit set.
- stage_ready  in  N_STAGES  per-kernel ap_ready.
- stage_done  in  N_STAGES  per-kernel ap_done.
- busy_stage  out  IW  index of the active stage; 0 when idle.
- stage_cycles  out  N_STAGES*CNT_W  per-stage cycle counts; stage i occupies bits [i*CNT_W +: CNT_W].
- err_timeout  out  1  sticky; set when the watchdog aborts a stage.
- err_stage  out  IW  index of the aborted stage.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE, ABORT.
- All outputs are decodes of registers. There is no combinational path from any input to any output.
- **IDLE**
  - ap_idle=1.
  - When ap_start=1, the run is accepted. In that cycle: latch stage_skip, clear stage_cycles, err_timeout and err_stage.
  - Next state: LAUNCH for the lowest-index non-skipped stage, or DONE if every stage is skipped.
  - ap_ready pulses in the cycle after acceptance.
- **LAUNCH (stage i)**
  - stage_start[i]=1; busy_stage=i.
  - stage_start[i] stays high until stage_ready[i] is sampled high, then moves to WAIT.
  - stage_done[i]=1 in LAUNCH counts as ready+done and completes the stage directly.
- **WAIT (stage i)**
  - stage_start=0.
  - On stage_done[i]=1 the stage completes.
- **Stage completion**
  - Next state: LAUNCH for the next higher non-skipped index, or DONE if none remains.
  - Skipped stages cost zero cycles.
- **stage_cycles[i]**
  - Counts every cycle of stage i in LAUNCH and WAIT, including the done cycle.
  - Saturates at 2^CNT_W-1.
  - Skipped stages read 0.
  - Held after the run until the next acceptance.
- **Watchdog**
  - If stage_cycles[i] reaches TIMEOUT without stage_done[i], go to ABORT.
  - ABORT lasts one cycle: stage_start=0, err_timeout=1, err_stage=i, then DONE.
  - Remaining stages are not run.
- **DONE**
  - ap_done=1 until ap_continue=1 is sampled, then IDLE.
  - ap_continue=1 in the first DONE cycle gives a one-cycle done.
- **Ignored inputs**
  - ap_start outside IDLE.
  - Any stage_ready or stage_done bit for a non-active stage.
- **Back-to-back runs:** ap_start held high re-accepts after at least one IDLE cycle.

## Timing
- Reset values: ap_idle=1; all other outputs 0, including stage_start, stage_cycles and busy_stage; state IDLE.
- Reset is asynchronous. Asserting ap_rst_n=0 mid-run drops stage_start immediately and discards the run. The bench expects no ap_done for the discarded run.
- Acceptance cycle t0: ap_ready=1 at t0+1, first LAUNCH at t0+1.
- A kernel with ready in its first LAUNCH cycle and done k cycles later occupies k+1 cycles. The next stage launches the cycle after done.
- Total latency, acceptance to first ap_done cycle: 1 + sum of the executed stage cycle counts.
- Watchdog: the abort is detected in the cycle stage_cycles[i] becomes TIMEOUT. ABORT follows in the next cycle, DONE one cycle after that.

## Test plan
- Nominal run:
  - Stimulus: reset, ap_start at t0; every kernel gives ready on its first start cycle and done 2 cycles later.
  - Required: ap_ready at t0+1; stage_start bits one-hot, in order 0,1,2,3; ap_done first high at t0+13; stage_cycles all 3; ap_continue at t0+15 → ap_idle at t0+16.
- Ready delay:
  - Stimulus: stage 2 asserts ready 4 cycles after start, done 1 cycle after ready.
  - Required: stage_start[2] high exactly 5 cycles; stage_cycles[2]=6.
- Skip mask:
  - Stimulus: stage_skip=4'b0101.
  - Required: only stages 1 and 3 launch; stage_cycles[0]=stage_cycles[2]=0.
  - Stimulus: stage_skip=4'b1111.
  - Required: ap_done at t0+1.
- Timeout:
  - Stimulus: TIMEOUT=8; stage 1 never asserts done.
  - Required: stage_start=0 after the abort; err_timeout=1, err_stage=1; stages 2 and 3 never start; ap_done asserted.
  - Stimulus: next accepted start.
  - Required: err_timeout clears.
- Protocol edges:
  - Stimulus: ap_start held high during a run.
  - Required: ignored.
  - Stimulus: done and ready in the same LAUNCH cycle.
  - Required: single-cycle stage.
  - Stimulus: stray done on an inactive stage.
  - Required: no effect.
  - Stimulus: ap_continue held low.
  - Required: ap_done held.
- Reset mid-WAIT:
  - Stimulus: assert ap_rst_n=0 during stage 2's WAIT.
  - Required: all outputs return to their reset values asynchronously.
  - Stimulus: a fresh run after reset.
  - Required: completes normally.
